// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared types and constants for the demux1x8 select
//                sequencer and its companion blocks. Holds the channel
//                geometry, the sequencer state type, the channel index type
//                and a helper that finds the lowest enabled channel of a mask.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int SEL_W  = 3;
    localparam int NUM_CH = 8;

    typedef logic [SEL_W-1:0] ch_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Lowest set bit of the mask; 0 when the mask is empty (callers never
    // use the result in that case).
    function automatic ch_idx_t first_enabled(input logic [NUM_CH-1:0] mask);
        ch_idx_t idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) idx = ch_idx_t'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_next_ch.sv
`default_nettype none
// ============================================================================
//  Module      : demux_next_ch
//  Description : Combinational round-robin step. Given a channel enable mask
//                and the current channel, returns the next enabled channel
//                strictly above the current one (modulo NUM_CH) and flags a
//                wrap when that next channel is not above the current one.
//                With only the current channel enabled the result is the
//                current channel itself and the wrap flag is set.
//  Ports       : i_mask [NUM_CH-1:0] channel enable mask
//                i_cur  [SEL_W-1:0]  current channel index
//                o_next [SEL_W-1:0]  next enabled channel index
//                o_wrap              next index <= current index
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_next_ch
    import demux_pkg::*;
(
    input  logic [NUM_CH-1:0] i_mask,
    input  ch_idx_t           i_cur,
    output ch_idx_t           o_next,
    output logic              o_wrap
);

    // Walk the distances from farthest to nearest so the nearest enabled
    // channel is the last assignment. Distance NUM_CH lands on i_cur itself,
    // which covers the single-channel case.
    always_comb begin
        o_next = i_cur;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (i_mask[i_cur + ch_idx_t'(i)]) o_next = i_cur + ch_idx_t'(i);
        end
        o_wrap = (o_next <= i_cur);
    end

endmodule
`default_nettype wire

// File: rtl/demux_sel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : demux_sel_sequencer
//  Description : Upstream driver for demux1x8. Accepts serial bits over a
//                valid/ready handshake and presents each bit on dm_in/dm_sel
//                for HOLD_CYCLES cycles, stepping round-robin through the
//                enabled channels. frame_done pulses on the return to WAIT
//                after the last enabled channel. All selection decisions are
//                registered so the demux itself stays combinational.
//  Option      : DEMUX_SEQ_PARITY_EN adds parity_out, the XOR of all bits of
//                the most recently completed frame.
//  Ports       : clk        rising-edge clock
//                rst_n      synchronous active-low reset
//                start      begin a run (IDLE only, needs ch_en != 0)
//                stop       finish the current frame, then go IDLE
//                ch_en      channel enable mask, captured on accepted start
//                s_valid    serial data valid
//                s_data     serial data bit
//                s_ready    block accepts a bit this cycle
//                dm_in      demux data, 0 while dm_strobe = 0
//                dm_sel     demux select, holds last value between strobes
//                dm_strobe  dm_in / dm_sel valid
//                frame_done one-cycle end-of-frame pulse
//                busy       not IDLE
//                parity_out frame parity (DEMUX_SEQ_PARITY_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_sel_sequencer #(
    parameter int SEL_W       = 3,
    parameter int NUM_CH      = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              s_valid,
    input  logic              s_data,
    output logic              s_ready,
    output logic              dm_in,
    output logic [SEL_W-1:0]  dm_sel,
    output logic              dm_strobe,
    output logic              frame_done,
    output logic              busy
`ifdef DEMUX_SEQ_PARITY_EN
    ,
    output logic              parity_out
`endif
);

    import demux_pkg::*;

    localparam logic [7:0] c_HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NUM_CH-1:0] r_mask;
    ch_idx_t           r_cur;
    ch_idx_t           r_sel;
    logic              r_data;
    logic [7:0]        r_cnt;
    logic              r_stop_pend;
    logic              r_frame_done;

    ch_idx_t           w_next;
    logic              w_wrap;
    logic              w_start_ok;
    logic              w_hold_last;
    logic              w_stop_eff;

    demux_next_ch u_next_ch (
        .i_mask (r_mask),
        .i_cur  (r_cur),
        .o_next (w_next),
        .o_wrap (w_wrap)
    );

    assign w_start_ok  = start && (ch_en != '0);
    assign w_hold_last = (r_state == HOLD) && (r_cnt == 8'd0);
    // A stop arriving in the very cycle the frame ends still counts.
    assign w_stop_eff  = r_stop_pend || stop;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_start_ok) w_state_nxt = WAIT;
            WAIT: if (s_valid)    w_state_nxt = HOLD;
            HOLD: begin
                if (w_hold_last) begin
                    w_state_nxt = (w_wrap && w_stop_eff) ? IDLE : WAIT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        s_ready    = (r_state == WAIT);
        dm_strobe  = (r_state == HOLD);
        dm_in      = r_data && (r_state == HOLD);
        dm_sel     = r_sel;
        frame_done = r_frame_done;
        busy       = (r_state != IDLE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mask       <= '0;
            r_cur        <= '0;
            r_sel        <= '0;
            r_data       <= 1'b0;
            r_cnt        <= 8'd0;
            r_stop_pend  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // stop is meaningless here and is simply dropped.
                    if (w_start_ok) begin
                        r_mask <= ch_en;
                        r_cur  <= first_enabled(ch_en);
                    end
                end
                WAIT: begin
                    if (stop) r_stop_pend <= 1'b1;
                    if (s_valid) begin
                        r_data <= s_data;
                        r_sel  <= r_cur;
                        r_cnt  <= c_HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (stop) r_stop_pend <= 1'b1;
                    if (!w_hold_last) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_cur <= w_next;
                        if (w_wrap) begin
                            r_frame_done <= 1'b1;
                            if (w_stop_eff) r_stop_pend <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DEMUX_SEQ_PARITY_EN
    logic r_acc;
    logic r_parity;

    // Accumulate every accepted bit; publish and clear at each frame end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc    <= 1'b0;
            r_parity <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_start_ok) r_acc <= 1'b0;
        end else if (r_state == WAIT) begin
            if (s_valid) r_acc <= r_acc ^ s_data;
        end else if (w_hold_last && w_wrap) begin
            r_parity <= r_acc;
            r_acc    <= 1'b0;
        end
    end

    assign parity_out = r_parity;
`endif

endmodule
`default_nettype wire

// File: doc/demux_sel_sequencer.md
Name: demux_sel_sequencer

Overview:
Upstream driver for demux1x8. It accepts a serial bit stream over a valid/ready handshake and presents each bit on the demux `in`/`sel` pair, stepping round-robin through the enabled channels. It holds each bit for a programmable number of cycles and signals end-of-frame after the last enabled channel. All selection decisions are registered, so the demux stays purely combinational.

Parameters:
- SEL_W, 3, select width driven to the demux.
- NUM_CH, 8, channel count; always equals 2**SEL_W.
- HOLD_CYCLES, 2, cycles each bit is held on dm_in/dm_sel; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  single-cycle request; begins a run when in IDLE.
- stop  input  1  single-cycle request; finishes the current frame, then goes to IDLE.
- ch_en  input  NUM_CH  channel enable mask; bit k enables channel k; captured on accepted start.
- s_valid  input  1  serial data valid.
- s_data  input  1  serial data bit.
- s_ready  output  1  block can accept a bit this cycle.
- dm_in  output  1  data to the demux `in`; 0 whenever dm_strobe=0.
- dm_sel  output  SEL_W  channel select to the demux `sel`.
- dm_strobe  output  1  dm_in/dm_sel are valid this cycle.
- frame_done  output  1  one-cycle pulse after the last enabled channel's hold completes.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at a clock edge) forces:
  - state to IDLE;
  - s_ready, dm_in, dm_strobe, frame_done, busy to 0;
  - dm_sel to 0;
  - mask register, hold counter and stop-pending flag to 0.
- Reset mid-hold or mid-frame abandons the frame with no frame_done pulse.
- States are IDLE, WAIT and HOLD.
- IDLE:
  - start=1 with ch_en!=0: capture mask, set current channel to the lowest enabled index, go to WAIT.
  - start=1 with ch_en==0: ignored; stay in IDLE.
- WAIT:
  - s_ready=1.
  - A transfer occurs when s_valid && s_ready.
  - On the next cycle: dm_in=s_data, dm_sel=current channel, dm_strobe=1, hold counter=HOLD_CYCLES-1, go to HOLD.
  - Latency from transfer to strobe is exactly 1 cycle.
- HOLD:
  - s_ready=0; dm_in, dm_sel and dm_strobe stay stable.
  - The counter decrements each cycle. At 0, dm_strobe and dm_in drop to 0 on the following cycle.
  - The current channel then advances to the next enabled index above it, wrapping modulo NUM_CH.
- Frame end: when the advance wraps, i.e. the next index is <= the current index:
  - frame_done pulses for 1 cycle, coincident with the return to WAIT.
  - If stop-pending is set, go to IDLE instead and clear stop-pending.
- A single enabled channel makes every bit a complete frame.
- stop:
  - In WAIT or HOLD, sets stop-pending. Data is never truncated mid-frame.
  - In IDLE, stop has no effect.
  - start and stop in the same IDLE cycle: start wins and stop is discarded.
- start while busy is ignored. ch_en changes while busy are ignored until the next accepted start.
- dm_sel holds its last value while dm_strobe=0. Downstream must gate on dm_strobe.

Optional Feature:
- Macro: DEMUX_SEQ_PARITY_EN.
- Enabled:
  - Adds output `parity_out` (1 bit), reset 0.
  - Holds the XOR of all bits of the just-completed frame; valid in the frame_done cycle and held until the next frame_done.
  - The accumulator clears at frame start.
- Disabled: the port and the accumulator are absent; all other behaviour is identical.

Decomposition:
- Package demux_pkg contains:
  - localparams SEL_W=3 and NUM_CH=8;
  - the state enum type (IDLE, WAIT, HOLD);
  - the channel index typedef (logic [SEL_W-1:0]).
- Sub-module demux_next_ch: combinational; inputs are the mask and the current index; outputs are the next enabled index and a wrap flag.
- demux_next_ch is reused later by the downstream capture bank.

Test Plan:
1. Reset and idle: rst_n=0 for 2 cycles, then idle.
   - All outputs are 0 while rst_n=0 and stay 0 afterwards.
   - start with ch_en=8'h00 leaves busy=0.
2. Full sweep: ch_en=8'hFF, HOLD_CYCLES=2, stream 1,0,1,1,0,0,1,0 with s_valid held high.
   - dm_sel steps 0..7, each strobed for 2 cycles, with dm_in matching the stream.
   - One frame_done follows the channel-7 hold.
3. Sparse mask: ch_en=8'b1010_0100, stream 1,1,1.
   - dm_sel sequence is 2, 5, 7.
   - frame_done pulses after channel 7; the next bit goes to channel 2.
4. Back-pressure and gaps: toggle s_valid randomly.
   - s_ready=0 throughout every HOLD cycle.
   - No bit is lost or duplicated; the strobe count equals the transfer count.
5. Stop mid-frame: ch_en=8'hFF, assert stop on the channel-3 strobe.
   - Channels 4..7 still complete, frame_done pulses, and the block ends in IDLE with busy=0.
6. Reset mid-hold: pull rst_n low during the channel-5 HOLD.
   - The next cycle shows dm_strobe=0, dm_sel=0 and no frame_done.
   - With DEMUX_SEQ_PARITY_EN, stream 1,1,1,0,0,0,0,1 gives parity_out=0.
